input_events: RTL and testbench
===============================

Name: input_events

Overview:
- Input-direction partner of the CPU I/O block.
- Samples and debounces the 10 toggle switches and 4 push keys.
- Detects level changes and queues them as event codes in a small FIFO. The CPU polls and pops the FIFO instead of reading raw switches.
- Input indices use the same switch numbering as the I/O block: 0-9 are toggles, 10-13 are keys.

Parameters:
- DEBOUNCE_CYCLES, 50000: sample-tick period in clocks (1 ms at 50 MHz); minimum 2.
- FIFO_DEPTH, 8: event FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- KeySwitches  input  4  raw keys, active-low (0 = pressed)
- ToggleSwitches  input  10  raw toggles, active-high
- ReadEvent  input  1  pop FIFO head on this clock edge
- ClearEvents  input  1  flush FIFO, pending edges and Overflow
- EventValid  output  1  FIFO not empty
- EventCode  output  32  FIFO head; [3:0] index, [4] new level (1 = on/pressed), [31:5] zero
- Pending  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- Overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous and active-high. Every register clears: synchronizers, tick counter, sample, stable, edge mask, FIFO pointers, Overflow. Outputs become EventValid=0, EventCode=0, Pending=0, Overflow=0. Reset mid-operation discards all queued and pending events.
- Input vector in[13:0] = {~KeySwitches, ToggleSwitches}. It passes through a 2-flop synchronizer per bit to give sync[13:0].
- Tick counter counts 0..DEBOUNCE_CYCLES-1 and wraps. tick=1 in the cycle the counter equals DEBOUNCE_CYCLES-1.
- On each tick, for every bit i:
  - sample[i] <= sync[i].
  - If sync[i]==sample[i] and sync[i]!=stable[i], then stable[i] <= sync[i] and edge mask bit i is set.
  - So a level must agree on two consecutive ticks. Any pulse shorter than DEBOUNCE_CYCLES clocks never produces an event.
- Drain, every cycle the mask is nonzero:
  - Select the lowest set index i.
  - Push {27'b0, stable[i], i[3:0]} and clear mask bit i.
  - Exactly one push per cycle. Multiple simultaneous edges are queued in ascending index order.
- Same-cycle set and clear of the same mask bit: set wins.
- Push while FIFO full and no pop in that cycle: the event is dropped, its mask bit is still cleared, and Overflow <= 1.
- Pop: on ReadEvent && EventValid the read pointer advances. ReadEvent while empty is ignored.
- Push and pop in the same cycle are both performed, including when full. Occupancy is unchanged and nothing is dropped.
- EventCode is the current head and is valid whenever EventValid=1. It reads zero when empty. EventValid and Pending update the cycle after a push or pop.
- ClearEvents has priority over ReadEvent, drain and tick mask-set in that cycle:
  - FIFO is emptied, mask is zeroed, Overflow=0.
  - stable and sample are kept, so no spurious events follow.
- Latency for a clean level change: 2 synchronizer clocks, then up to 2 tick periods, then 1 drain cycle, then EventValid on the next edge.
- Toggles already on at reset are reported as events once debounced. This gives the CPU its initial state.

Decomposition:
- Package io_pkg holds: NUM_TOGGLE=10, NUM_KEY=4, NUM_INPUTS=14, KEY_BASE=10, and the EventCode field positions (IDX_LSB=0, IDX_W=4, LEVEL_BIT=4).
- Sub-module event_fifo: synchronous FIFO (DEPTH, WIDTH=5) with push, pop, clear, full, empty and count outputs, and the same clock/reset.
- The top level holds the synchronizers, tick counter, debounce registers and priority drain.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
1. Reset asserted with toggles=0 and keys=4'hF -> EventValid=0, EventCode=0, Pending=0, Overflow=0 held for 50 cycles. Reset asserted mid-queue -> same values immediately, without waiting for a clock.
2. ToggleSwitches[3]=1 held -> exactly one event, EventCode=32'h13, Pending=1, within 2+8+2 cycles. ReadEvent one cycle -> EventValid=0. No further events.
3. KeySwitches[1]=0 for 3 cycles, then back to 1 -> no event ever.
4. KeySwitches[2]=0 held -> EventCode=32'h1C. Then release -> 32'h0C.
5. ToggleSwitches[5:0] go to 6'h3F in one cycle with no reads -> FIFO holds 0x10, 0x11, 0x12, 0x13 in that order. Indices 4 and 5 are dropped, Overflow=1, Pending=4. ClearEvents -> Pending=0, Overflow=0, and no re-report of any toggle.
6. With FIFO full, ReadEvent coincides with a push -> head advances, the new event is appended at the tail, Pending stays 4, Overflow stays 0. ReadEvent while empty -> no change.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the switch/key input path and the event code layout.
package io_pkg;
  localparam int NUM_TOGGLE = 10;
  localparam int NUM_KEY    = 4;
  localparam int NUM_INPUTS = NUM_TOGGLE + NUM_KEY;
  localparam int KEY_BASE   = NUM_TOGGLE;

  localparam int IDX_LSB   = 0;
  localparam int IDX_W     = 4;
  localparam int LEVEL_BIT = 4;
  localparam int EVT_W     = LEVEL_BIT + 1;

  typedef struct packed {
    logic             level;
    logic [IDX_W-1:0] idx;
  } evt_t;
endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO; push and pop together are both honoured even when full.
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           headData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] wrPtr, rdPtr;
  logic          doPush, doPop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/input_events.sv
// Synchronize and debounce toggles/keys, queue level changes as event codes.
module input_events
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_KEY-1:0]              KeySwitches,
  input  logic [NUM_TOGGLE-1:0]           ToggleSwitches,
  input  logic                            ReadEvent,
  input  logic                            ClearEvents,
  output logic                            EventValid,
  output logic [31:0]                     EventCode,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] Pending,
  output logic                            Overflow
);
  localparam int TW = $clog2(DEBOUNCE_CYCLES);

  logic [NUM_INPUTS-1:0] rawIn, sync1, sync2, sample, stable, edgeMask;
  logic [NUM_INPUTS-1:0] setBits, clrBits;
  logic [TW-1:0]         tickCount;
  logic                  tick;
  logic [IDX_W-1:0]      drainIdx;
  logic                  drainValid;
  evt_t                  pushEvt, headEvt;
  logic                  fifoFull, fifoEmpty, popEn;

  assign rawIn = {~KeySwitches, ToggleSwitches};
  assign tick  = (tickCount == TW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      tickCount <= '0;
      sample    <= '0;
      stable    <= '0;
    end else begin
      sync1     <= rawIn;
      sync2     <= sync1;
      tickCount <= tick ? '0 : tickCount + 1'b1;
      if (tick) begin
        sample <= sync2;
        stable <= stable ^ setBits;
      end
    end
  end

  // A bit is accepted once two consecutive ticks agree and it differs from stable.
  assign setBits = tick ? ((sync2 ~^ sample) & (sync2 ^ stable)) : '0;

  always_comb begin
    drainIdx   = '0;
    drainValid = |edgeMask;
    for (int i = NUM_INPUTS - 1; i >= 0; i--)
      if (edgeMask[i]) drainIdx = IDX_W'(i);
  end

  assign clrBits       = drainValid ? (NUM_INPUTS'(1) << drainIdx) : '0;
  assign pushEvt.level = stable[drainIdx];
  assign pushEvt.idx   = drainIdx;
  assign popEn         = ReadEvent && !fifoEmpty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edgeMask <= '0;
      Overflow <= 1'b0;
    end else if (ClearEvents) begin
      edgeMask <= '0;
      Overflow <= 1'b0;
    end else begin
      edgeMask <= (edgeMask & ~clrBits) | setBits;
      if (drainValid && fifoFull && !popEn) Overflow <= 1'b1;
    end
  end

  event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EVT_W)) uFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (drainValid),
    .pushData (pushEvt),
    .pop      (ReadEvent),
    .clear    (ClearEvents),
    .headData (headEvt),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (Pending)
  );

  assign EventValid = !fifoEmpty;
  assign EventCode  = fifoEmpty ? 32'h0 : {27'b0, headEvt};
endmodule

// File: tb/tb_input_events.sv
// Directed bench for input_events with a short debounce period and 4-entry FIFO.
module tb_input_events;
  logic        clock = 0, reset = 1;
  logic [3:0]  KeySwitches = 4'hF;
  logic [9:0]  ToggleSwitches = '0;
  logic        ReadEvent = 0, ClearEvents = 0;
  logic        EventValid, Overflow;
  logic [31:0] EventCode;
  logic [2:0]  Pending;
  int checks = 0, failures = 0;

  input_events #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .KeySwitches(KeySwitches),
    .ToggleSwitches(ToggleSwitches), .ReadEvent(ReadEvent),
    .ClearEvents(ClearEvents), .EventValid(EventValid),
    .EventCode(EventCode), .Pending(Pending), .Overflow(Overflow));

  always #5 clock = ~clock;

  task automatic pop_one();
    @(negedge clock); ReadEvent = 1;
    @(posedge clock); #1 ReadEvent = 0;
    @(negedge clock);
  endtask

  // Waits on negedges until EventValid or budget runs out; reports edges waited.
  task automatic wait_valid(input int budget, output bit got, output int waited);
    got = 0; waited = 0;
    while (!got && waited < budget) begin
      @(negedge clock); waited++;
      if (EventValid) got = 1;
    end
  endtask

  task automatic wait_pending(input logic [2:0] want, input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (Pending == want) got = 1;
    end
  endtask

  task automatic test_reset();
    bit bad = 0;
    reset = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (EventValid !== 0 || EventCode !== 0 || Pending !== 0 || Overflow !== 0) bad = 1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL reset_hold: outputs not all zero during reset (ev=%b code=%h pend=%0d ovf=%b)", EventValid, EventCode, Pending, Overflow); end
    reset = 0;
  endtask

  task automatic test_toggle();
    bit got; int w;
    @(negedge clock); ToggleSwitches[3] = 1;
    wait_valid(12, got, w);
    checks++; if (!got) begin failures++; $display("FAIL toggle_latency: no event within 12 cycles, required EventValid=1"); end
    checks++; if (EventCode !== 32'h13) begin failures++; $display("FAIL toggle_code: got %h want 13", EventCode); end
    checks++; if (Pending !== 1) begin failures++; $display("FAIL toggle_pending: got %0d want 1", Pending); end
    pop_one();
    checks++; if (EventValid !== 0) begin failures++; $display("FAIL toggle_pop: EventValid=%b want 0", EventValid); end
    repeat (20) @(negedge clock);
    checks++; if (EventValid !== 0 || Pending !== 0) begin failures++; $display("FAIL toggle_quiet: ev=%b pend=%0d want 0 0", EventValid, Pending); end
    ToggleSwitches[3] = 0;
    wait_valid(12, got, w);
    checks++; if (EventCode !== 32'h03) begin failures++; $display("FAIL toggle_off: got %h want 03", EventCode); end
    pop_one();
  endtask

  task automatic test_glitch();
    bit got; int w;
    @(negedge clock); KeySwitches[1] = 0;
    repeat (3) @(negedge clock);
    KeySwitches[1] = 1;
    wait_valid(40, got, w);
    checks++; if (got) begin failures++; $display("FAIL key_glitch: event %h appeared, want none", EventCode); end
  endtask

  task automatic test_key();
    bit got; int w;
    @(negedge clock); KeySwitches[2] = 0;
    wait_valid(12, got, w);
    checks++; if (!got || EventCode !== 32'h1C) begin failures++; $display("FAIL key_press: got %h valid=%b want 1c", EventCode, got); end
    pop_one();
    KeySwitches[2] = 1;
    wait_valid(12, got, w);
    checks++; if (!got || EventCode !== 32'h0C) begin failures++; $display("FAIL key_release: got %h valid=%b want 0c", EventCode, got); end
    pop_one();
  endtask

  task automatic test_reset_midqueue();
    bit got; int w;
    @(negedge clock); ToggleSwitches[7] = 1;
    wait_valid(12, got, w);
    checks++; if (EventCode !== 32'h17) begin failures++; $display("FAIL midq_setup: got %h want 17", EventCode); end
    #2 reset = 1;
    #1;
    checks++;
    if (EventValid !== 0 || EventCode !== 0 || Pending !== 0 || Overflow !== 0) begin
      failures++; $display("FAIL midq_async: ev=%b code=%h pend=%0d ovf=%b want all 0", EventValid, EventCode, Pending, Overflow);
    end
    @(negedge clock); reset = 0;
    wait_valid(14, got, w);
    checks++; if (!got || EventCode !== 32'h17) begin failures++; $display("FAIL midq_rereport: got %h want 17", EventCode); end
    pop_one();
  endtask

  task automatic test_overflow_clear();
    bit got; int w;
    @(negedge clock); ToggleSwitches[5:0] = 6'h3F;
    wait_pending(3'd4, 16, got);
    repeat (6) @(negedge clock);
    checks++; if (Pending !== 4) begin failures++; $display("FAIL ovf_pending: got %0d want 4", Pending); end
    checks++; if (Overflow !== 1) begin failures++; $display("FAIL ovf_flag: got %b want 1", Overflow); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (EventCode !== 32'h10 + i) begin failures++; $display("FAIL ovf_order%0d: got %h want %h", i, EventCode, 32'h10 + i); end
      pop_one();
    end
    checks++; if (EventCode !== 32'h13) begin failures++; $display("FAIL ovf_tail: got %h want 13", EventCode); end
    @(negedge clock); ClearEvents = 1;
    @(posedge clock); #1 ClearEvents = 0;
    @(negedge clock);
    checks++; if (Pending !== 0 || Overflow !== 0 || EventValid !== 0) begin failures++; $display("FAIL clear: pend=%0d ovf=%b ev=%b want 0 0 0", Pending, Overflow, EventValid); end
    wait_valid(30, got, w);
    checks++; if (got) begin failures++; $display("FAIL clear_rereport: event %h after clear, want none", EventCode); end
  endtask

  task automatic test_back_to_back();
    bit got;
    @(negedge clock); ToggleSwitches[4:0] = 5'h00;
    wait_pending(3'd4, 16, got);
    checks++; if (!got) begin failures++; $display("FAIL b2b_fill: Pending=%0d want 4", Pending); end
    ReadEvent = 1;
    @(posedge clock); #1 ReadEvent = 0;
    @(negedge clock);
    checks++; if (Pending !== 4 || Overflow !== 0) begin failures++; $display("FAIL b2b_simul: pend=%0d ovf=%b want 4 0", Pending, Overflow); end
    repeat (10) @(negedge clock);
    for (int i = 1; i <= 4; i++) begin
      checks++; if (EventCode !== i) begin failures++; $display("FAIL b2b_order%0d: got %h want %h", i, EventCode, i); end
      pop_one();
    end
    checks++; if (Overflow !== 0) begin failures++; $display("FAIL b2b_ovf: got %b want 0", Overflow); end
    pop_one();
    checks++; if (Pending !== 0 || EventValid !== 0 || EventCode !== 0) begin failures++; $display("FAIL empty_read: pend=%0d ev=%b code=%h want 0", Pending, EventValid, EventCode); end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_glitch();
    test_key();
    test_reset_midqueue();
    test_overflow_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
